bbox_tracker: RTL and testbench

- Inverse of the sprite renderers: takes a per-pixel detection mask in raster order and produces the bounding box of all set pixels each frame.
- Box outputs drive the xmin/ymin/xmax/ymax inputs of the min/max box renderer directly, for on-screen overlay of a tracked object.
- Sits between the pixel classifier (colour threshold) and the overlay renderers.
- Adds a noise floor (minimum pixel count) and a lost-object timeout across frames.

---
 rtl/bbox_tracker.sv | 146 ++++++++++++++
 tb/tb_bbox_tracker.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bbox_tracker.sv
// Bounding-box tracker: folds a raster-order detection mask into a per-frame
// box, with a minimum-pixel noise floor and a lost-object timeout.
// Ports: clk_in/rst_in (async active-low); hcount_in/vcount_in/valid_in/
// mask_in pixel stream; xmin/ymin/xmax/ymax_out box of the last hit frame;
// count_out set pixels of last frame; box_valid_out box still current;
// frame_done_out one-cycle pulse per committed frame.
module bbox_tracker #(
    parameter int H_ACTIVE    = 1280,
    parameter int V_ACTIVE    = 720,
    parameter int MIN_PIXELS  = 16,
    parameter int MISS_FRAMES = 3
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        valid_in,
    input  logic        mask_in,
    output logic [11:0] xmin_out,
    output logic [10:0] ymin_out,
    output logic [11:0] xmax_out,
    output logic [10:0] ymax_out,
    output logic [19:0] count_out,
    output logic        box_valid_out,
    output logic        frame_done_out
);

    localparam int MW = $clog2(MISS_FRAMES + 1);

    localparam logic [11:0]   LP_H_LIM  = 12'(H_ACTIVE);
    localparam logic [10:0]   LP_V_LIM  = 11'(V_ACTIVE);
    localparam logic [10:0]   LP_H_LAST = 11'(H_ACTIVE - 1);
    localparam logic [9:0]    LP_V_LAST = 10'(V_ACTIVE - 1);
    localparam logic [19:0]   LP_MIN    = 20'(MIN_PIXELS);
    localparam logic [MW-1:0] LP_MISS   = MW'(MISS_FRAMES);

    // Stage 1 pixel register
    logic        r_valid;
    logic        r_mask;
    logic [10:0] r_h;
    logic [9:0]  r_v;

    // Stage 2 accumulator and miss counter
    logic [11:0]   r_min_x;
    logic [10:0]   r_min_y;
    logic [11:0]   r_max_x;
    logic [10:0]   r_max_y;
    logic [19:0]   r_cnt;
    logic [MW-1:0] r_miss;

    logic [11:0]   w_x;
    logic [10:0]   w_y;
    logic          w_hit;
    logic          w_last;
    logic [11:0]   w_min_x;
    logic [10:0]   w_min_y;
    logic [11:0]   w_max_x;
    logic [10:0]   w_max_y;
    logic [19:0]   w_cnt;
    logic          w_hit_frame;
    logic [MW-1:0] w_miss_nxt;

    assign w_x = {1'b0, r_h};
    assign w_y = {1'b0, r_v};

    assign w_hit = r_valid && r_mask
                && (w_x < LP_H_LIM) && (w_y < LP_V_LIM);

    // Frame end is positional only; the mask plays no part.
    assign w_last = r_valid && (r_h == LP_H_LAST) && (r_v == LP_V_LAST);

    // Accumulator with the current pixel folded in; used both for the
    // running update and for the commit so the final pixel is counted.
    assign w_min_x = (w_hit && (w_x < r_min_x)) ? w_x : r_min_x;
    assign w_min_y = (w_hit && (w_y < r_min_y)) ? w_y : r_min_y;
    assign w_max_x = (w_hit && (w_x > r_max_x)) ? w_x : r_max_x;
    assign w_max_y = (w_hit && (w_y > r_max_y)) ? w_y : r_max_y;
    assign w_cnt   = (w_hit && (r_cnt != '1)) ? r_cnt + 20'd1 : r_cnt;

    assign w_hit_frame = (w_cnt >= LP_MIN);
    assign w_miss_nxt  = (r_miss == LP_MISS) ? r_miss : r_miss + MW'(1);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_valid <= 1'b0;
            r_mask  <= 1'b0;
            r_h     <= '0;
            r_v     <= '0;
        end else begin
            r_valid <= valid_in;
            r_mask  <= mask_in;
            r_h     <= hcount_in;
            r_v     <= vcount_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_min_x        <= 12'hFFF;
            r_min_y        <= 11'h7FF;
            r_max_x        <= '0;
            r_max_y        <= '0;
            r_cnt          <= '0;
            r_miss         <= '0;
            xmin_out       <= '0;
            ymin_out       <= '0;
            xmax_out       <= '0;
            ymax_out       <= '0;
            count_out      <= '0;
            box_valid_out  <= 1'b0;
            frame_done_out <= 1'b0;
        end else begin
            frame_done_out <= w_last;
            if (w_last) begin
                // Empty the accumulator on the commit edge so the next
                // cycle's pixel starts the new frame.
                r_min_x   <= 12'hFFF;
                r_min_y   <= 11'h7FF;
                r_max_x   <= '0;
                r_max_y   <= '0;
                r_cnt     <= '0;
                count_out <= w_cnt;
                if (w_hit_frame) begin
                    xmin_out      <= w_min_x;
                    ymin_out      <= w_min_y;
                    xmax_out      <= w_max_x;
                    ymax_out      <= w_max_y;
                    box_valid_out <= 1'b1;
                    r_miss        <= '0;
                end else begin
                    r_miss <= w_miss_nxt;
                    if (w_miss_nxt == LP_MISS) begin
                        box_valid_out <= 1'b0;
                    end
                end
            end else begin
                r_min_x <= w_min_x;
                r_min_y <= w_min_y;
                r_max_x <= w_max_x;
                r_max_y <= w_max_y;
                r_cnt   <= w_cnt;
            end
        end
    end

endmodule

// File: tb/tb_bbox_tracker.sv
// Self-checking bench for bbox_tracker: sparse pixel streams at full
// resolution, checked against a queue-based per-frame box model.
module tb_bbox_tracker;

    localparam int HA   = 1280;
    localparam int VA   = 720;
    localparam int MINP = 16;
    localparam int MISS = 3;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        valid_in;
    logic        mask_in;
    logic [11:0] xmin_out;
    logic [10:0] ymin_out;
    logic [11:0] xmax_out;
    logic [10:0] ymax_out;
    logic [19:0] count_out;
    logic        box_valid_out;
    logic        frame_done_out;

    bbox_tracker dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .hcount_in      (hcount_in),
        .vcount_in      (vcount_in),
        .valid_in       (valid_in),
        .mask_in        (mask_in),
        .xmin_out       (xmin_out),
        .ymin_out       (ymin_out),
        .xmax_out       (xmax_out),
        .ymax_out       (ymax_out),
        .count_out      (count_out),
        .box_valid_out  (box_valid_out),
        .frame_done_out (frame_done_out)
    );

    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;

    // Model: hit pixels of the open frame, plus expected outputs.
    int          qx[$];
    int          qy[$];
    logic [11:0] e_xmin, e_xmax;
    logic [10:0] e_ymin, e_ymax;
    logic [19:0] e_cnt;
    logic        e_valid;
    int          e_miss;

    // Output snapshot taken at the negedge where each drive happens.
    logic [11:0] s_xmin, s_xmax;
    logic [10:0] s_ymin, s_ymax;
    logic [19:0] s_cnt;
    logic        s_bv, s_fd;
    logic        fd_pre, fd_at, fd_post;

    task automatic model_reset();
        qx.delete();
        qy.delete();
        e_xmin = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0;
        e_cnt = 0; e_valid = 0; e_miss = 0;
    endtask

    task automatic model_commit();
        int n;
        int mnx, mny, mxx, mxy;
        n = qx.size();
        e_cnt = (n > 20'hFFFFF) ? 20'hFFFFF : 20'(n);
        if (n >= MINP) begin
            mnx = 4095; mny = 2047; mxx = 0; mxy = 0;
            foreach (qx[i]) begin
                if (qx[i] < mnx) mnx = qx[i];
                if (qx[i] > mxx) mxx = qx[i];
                if (qy[i] < mny) mny = qy[i];
                if (qy[i] > mxy) mxy = qy[i];
            end
            e_xmin = 12'(mnx); e_xmax = 12'(mxx);
            e_ymin = 11'(mny); e_ymax = 11'(mxy);
            e_valid = 1'b1;
            e_miss = 0;
        end else begin
            if (e_miss < MISS) e_miss++;
            if (e_miss == MISS) e_valid = 1'b0;
        end
        qx.delete();
        qy.delete();
    endtask

    task automatic send_px(input int h, input int v,
                           input logic vl, input logic m);
        @(negedge clk_in);
        s_xmin = xmin_out; s_xmax = xmax_out;
        s_ymin = ymin_out; s_ymax = ymax_out;
        s_cnt = count_out; s_bv = box_valid_out;
        s_fd = frame_done_out;
        hcount_in = 11'(h);
        vcount_in = 10'(v);
        valid_in  = vl;
        mask_in   = m;
        if (vl && m && h < HA && v < VA) begin
            qx.push_back(h);
            qy.push_back(v);
        end
        if (vl && h == HA - 1 && v == VA - 1) model_commit();
    endtask

    task automatic finish_frame(input logic m);
        send_px(HA - 1, VA - 1, 1'b1, m);
        send_px(0, 0, 1'b0, 1'b0);
        fd_pre = s_fd;
        send_px(0, 0, 1'b0, 1'b0);
        fd_at = s_fd;
        send_px(0, 0, 1'b0, 1'b0);
        fd_post = s_fd;
    endtask

    task automatic fill_box(input int x0, input int x1,
                            input int y0, input int y1);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
                send_px(x, y, 1'b1, 1'b1);
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        valid_in = 0; mask_in = 0; hcount_in = 0; vcount_in = 0;
        model_reset();
        #3;
        total++;
        if ({xmin_out, ymin_out, xmax_out, ymax_out, count_out,
             box_valid_out, frame_done_out} !== 88'd0) begin
            bad++;
            $display("FAIL reset: got %h %h %h %h %h %b %b want zeros",
                     xmin_out, ymin_out, xmax_out, ymax_out,
                     count_out, box_valid_out, frame_done_out);
        end
        @(negedge clk_in);
        rst_in = 1'b1;
    endtask

    task automatic test_box();
        fill_box(100, 119, 50, 59);
        finish_frame(1'b0);
        total++;
        if ({s_xmin, s_ymin, s_xmax, s_ymax, s_cnt, s_bv} !==
            {12'd100, 11'd50, 12'd119, 11'd59, 20'd200, 1'b1}) begin
            bad++;
            $display("FAIL box: got %0d %0d %0d %0d cnt=%0d v=%b want 100 50 119 59 cnt=200 v=1",
                     s_xmin, s_ymin, s_xmax, s_ymax, s_cnt, s_bv);
        end
        total++;
        if ({fd_pre, fd_at, fd_post} !== 3'b010) begin
            bad++;
            $display("FAIL box_pulse: got %b%b%b want 010",
                     fd_pre, fd_at, fd_post);
        end
    endtask

    task automatic test_miss();
        fill_box(30, 39, 5, 6);
        finish_frame(1'b0);
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 3; k++)
                send_px($urandom_range(0, 1200), $urandom_range(0, 700),
                        1'b1, 1'b1);
            finish_frame(1'b0);
            total++;
            if ({s_xmin, s_ymin, s_xmax, s_ymax, s_cnt, s_bv} !==
                {12'd30, 11'd5, 12'd39, 11'd6, 20'd3, logic'(f < 2)}) begin
                bad++;
                $display("FAIL miss%0d: got %0d %0d %0d %0d cnt=%0d v=%b want 30 5 39 6 cnt=3 v=%b",
                         f, s_xmin, s_ymin, s_xmax, s_ymax, s_cnt, s_bv,
                         f < 2);
            end
        end
        fill_box(200, 203, 400, 404);
        finish_frame(1'b1);
        total++;
        if ({s_xmin, s_ymin, s_xmax, s_ymax, s_cnt, s_bv} !==
            {e_xmin, e_ymin, e_xmax, e_ymax, e_cnt, e_valid}) begin
            bad++;
            $display("FAIL miss_recover: got %0d %0d %0d %0d cnt=%0d v=%b want %0d %0d %0d %0d cnt=%0d v=%b",
                     s_xmin, s_ymin, s_xmax, s_ymax, s_cnt, s_bv,
                     e_xmin, e_ymin, e_xmax, e_ymax, e_cnt, e_valid);
        end
    endtask

    // (0,0) repeated to lift the count to the noise floor; the final
    // pixel itself carries the far corner.
    task automatic test_corners();
        for (int k = 0; k < MINP - 1; k++) send_px(0, 0, 1'b1, 1'b1);
        finish_frame(1'b1);
        total++;
        if ({s_xmin, s_ymin, s_xmax, s_ymax, s_cnt, s_bv} !==
            {12'd0, 11'd0, 12'd1279, 11'd719, 20'd16, 1'b1}) begin
            bad++;
            $display("FAIL corners: got %0d %0d %0d %0d cnt=%0d v=%b want 0 0 1279 719 cnt=16 v=1",
                     s_xmin, s_ymin, s_xmax, s_ymax, s_cnt, s_bv);
        end
    endtask

    task automatic test_ignored();
        send_px(500, 100, 1'b0, 1'b1);
        send_px(HA - 1, VA - 1, 1'b0, 1'b1);
        send_px(1300, 100, 1'b1, 1'b1);
        send_px(100, 730, 1'b1, 1'b1);
        send_px(2047, 1023, 1'b1, 1'b1);
        finish_frame(1'b0);
        total++;
        if ({s_xmin, s_ymin, s_xmax, s_ymax, s_cnt, s_bv} !==
            {12'd0, 11'd0, 12'd1279, 11'd719, 20'd0, 1'b1}) begin
            bad++;
            $display("FAIL ignored: got %0d %0d %0d %0d cnt=%0d v=%b want 0 0 1279 719 cnt=0 v=1",
                     s_xmin, s_ymin, s_xmax, s_ymax, s_cnt, s_bv);
        end
    endtask

    task automatic test_back_to_back();
        logic p0, p1;
        send_px(10, 10, 1'b1, 1'b1);
        send_px(20, 20, 1'b1, 1'b1);
        for (int k = 0; k < 14; k++)
            send_px($urandom_range(10, 20), $urandom_range(10, 20),
                    1'b1, 1'b1);
        send_px(HA - 1, VA - 1, 1'b1, 1'b0);
        send_px(500, 300, 1'b1, 1'b1);
        p0 = s_fd;
        send_px(510, 305, 1'b1, 1'b1);
        p1 = s_fd;
        total++;
        if ({s_xmin, s_ymin, s_xmax, s_ymax, s_cnt, s_bv, p0, p1} !==
            {12'd10, 11'd10, 12'd20, 11'd20, 20'd16, 1'b1, 2'b01}) begin
            bad++;
            $display("FAIL b2b_first: got %0d %0d %0d %0d cnt=%0d v=%b fd=%b%b want 10 10 20 20 cnt=16 v=1 fd=01",
                     s_xmin, s_ymin, s_xmax, s_ymax, s_cnt, s_bv, p0, p1);
        end
        for (int k = 0; k < 14; k++)
            send_px($urandom_range(500, 510), $urandom_range(300, 305),
                    1'b1, 1'b1);
        finish_frame(1'b0);
        total++;
        if ({s_xmin, s_ymin, s_xmax, s_ymax, s_cnt, s_bv} !==
            {12'd500, 11'd300, 12'd510, 11'd305, 20'd16, 1'b1}) begin
            bad++;
            $display("FAIL b2b_second: got %0d %0d %0d %0d cnt=%0d v=%b want 500 300 510 305 cnt=16 v=1",
                     s_xmin, s_ymin, s_xmax, s_ymax, s_cnt, s_bv);
        end
    endtask

    task automatic test_random();
        int x0, y0, w, h, n, r;
        for (int f = 0; f < 12; f++) begin
            x0 = $urandom_range(0, 1200);
            y0 = $urandom_range(0, 700);
            w  = $urandom_range(0, 60);
            h  = $urandom_range(0, 15);
            n  = $urandom_range(0, 40);
            for (int k = 0; k < n; k++) begin
                r = $urandom_range(0, 99);
                if (r < 8)
                    send_px(x0, y0, 1'b0, 1'($urandom_range(0, 1)));
                else if (r < 12)
                    send_px($urandom_range(1280, 2047), y0, 1'b1, 1'b1);
                else
                    send_px(x0 + $urandom_range(0, w),
                            y0 + $urandom_range(0, h), 1'b1,
                            logic'($urandom_range(0, 9) < 8));
            end
            finish_frame(1'($urandom_range(0, 1)));
            total++;
            if ({s_xmin, s_ymin, s_xmax, s_ymax, s_cnt, s_bv,
                 fd_pre, fd_at, fd_post} !==
                {e_xmin, e_ymin, e_xmax, e_ymax, e_cnt, e_valid,
                 3'b010}) begin
                bad++;
                $display("FAIL random%0d: got %0d %0d %0d %0d cnt=%0d v=%b fd=%b%b%b want %0d %0d %0d %0d cnt=%0d v=%b fd=010",
                         f, s_xmin, s_ymin, s_xmax, s_ymax, s_cnt, s_bv,
                         fd_pre, fd_at, fd_post, e_xmin, e_ymin, e_xmax,
                         e_ymax, e_cnt, e_valid);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 5; k++)
            send_px(700 + k, 600, 1'b1, 1'b1);
        #2;
        rst_in = 1'b0;
        model_reset();
        #1;
        total++;
        if ({xmin_out, ymin_out, xmax_out, ymax_out, count_out,
             box_valid_out, frame_done_out} !== 88'd0) begin
            bad++;
            $display("FAIL reset_mid: got %h %h %h %h %h %b %b want zeros",
                     xmin_out, ymin_out, xmax_out, ymax_out,
                     count_out, box_valid_out, frame_done_out);
        end
        @(negedge clk_in);
        valid_in = 1'b0;
        rst_in = 1'b1;
        fill_box(40, 43, 80, 84);
        finish_frame(1'b0);
        total++;
        if ({s_xmin, s_ymin, s_xmax, s_ymax, s_cnt, s_bv} !==
            {12'd40, 11'd80, 12'd43, 11'd84, 20'd20, 1'b1}) begin
            bad++;
            $display("FAIL reset_post: got %0d %0d %0d %0d cnt=%0d v=%b want 40 80 43 84 cnt=20 v=1",
                     s_xmin, s_ymin, s_xmax, s_ymax, s_cnt, s_bv);
        end
    endtask

    initial begin
        test_reset();
        test_box();
        test_miss();
        test_corners();
        test_ignored();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
